// File: rtl/fp_max_reduce.sv
// Streaming binary32 max-reduction: interleaves partial maxima across NSLOT slots so the
// pipelined max core takes one element per cycle, then folds the slots into one result per sequence.

module fp_max_core #(
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] q_o
);

  logic [31:0] pipe_q [LATENCY];

  // maxNum behaviour: a single NaN loses to the number, two NaNs give the canonical quiet NaN,
  // and +0 beats -0 because the sign decides first.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    if (a_nan && b_nan) return 32'h7FC0_0000;
    if (a_nan) return b;
    if (b_nan) return a;
    if (a[31] != b[31]) return a[31] ? b : a;
    if (!a[31]) return (a[30:0] >= b[30:0]) ? a : b;
    return (a[30:0] <= b[30:0]) ? a : b;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= fmax(a_i, b_i);
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[LATENCY-1];

endmodule

module fp_max_reduce #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam int NSLOT = LATENCY + 1;
  localparam int PTR_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [31:0]      NEG_INF  = 32'hFF80_0000;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NSLOT - 1);
  localparam logic [PTR_W-1:0] STEP_END = PTR_W'(LATENCY);

  typedef enum logic [1:0] {ACCUM, DRAIN, FOLD, OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      slot_q [NSLOT];
  logic [31:0]      slot_d [NSLOT];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0] tag_ptr_q [LATENCY];
  logic [PTR_W-1:0] tag_ptr_d [LATENCY];
  logic [31:0]      acc_q, acc_d;
  logic [PTR_W-1:0] fidx_q, fidx_d;
  logic [PTR_W-1:0] fcnt_q, fcnt_d;

  logic        accept;
  logic        out_xfer;
  logic        drain_done;
  logic        wb_vld;
  logic [PTR_W-1:0] wb_ptr;
  logic [31:0] core_a, core_b, core_q;

  fp_max_core #(.LATENCY(LATENCY)) u_core (
    .clock (clock),
    .reset (reset),
    .a_i   (core_a),
    .b_i   (core_b),
    .q_o   (core_q)
  );

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign wb_vld   = tag_vld_q[LATENCY-1];
  assign wb_ptr   = tag_ptr_q[LATENCY-1];

  // The tag leaving the pipe this cycle lands before FOLD starts, so only the younger ones matter.
  always_comb begin
    drain_done = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++) begin
      if (tag_vld_q[i]) drain_done = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ACCUM;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      acc_q     <= '0;
      fidx_q    <= PTR_W'(1);
      fcnt_q    <= '0;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= NEG_INF;
      for (int i = 0; i < LATENCY; i++) tag_ptr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      acc_q     <= acc_d;
      fidx_q    <= fidx_d;
      fcnt_q    <= fcnt_d;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= slot_d[i];
      for (int i = 0; i < LATENCY; i++) tag_ptr_q[i] <= tag_ptr_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = FOLD;
      FOLD:    if (fcnt_q == STEP_END && fidx_q == PTR_LAST) state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM) && !reset;
    out_valid = (state_q == OUTPUT);
    out_data  = acc_q;
    out_count = cnt_q;
  end

  // During FOLD the first step takes slot 0 as its running value; later steps use acc.
  always_comb begin
    if (state_q == FOLD) begin
      core_a = (fidx_q == PTR_W'(1)) ? slot_q[0] : acc_q;
      core_b = slot_q[fidx_q];
    end else begin
      core_a = in_data;
      core_b = slot_q[ptr_q];
    end
  end

  always_comb begin
    slot_d    = slot_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tag_vld_d = tag_vld_q;
    tag_ptr_d = tag_ptr_q;
    acc_d     = acc_q;
    fidx_d    = fidx_q;
    fcnt_d    = fcnt_q;

    for (int i = LATENCY - 1; i > 0; i--) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ptr_d[i] = tag_ptr_q[i-1];
    end
    tag_vld_d[0] = accept;
    tag_ptr_d[0] = ptr_q;

    if (wb_vld) slot_d[wb_ptr] = core_q;

    if (accept) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    if (state_q == FOLD) begin
      if (fcnt_q == STEP_END) begin
        acc_d  = core_q;
        fcnt_d = '0;
        fidx_d = fidx_q + PTR_W'(1);
      end else begin
        fcnt_d = fcnt_q + PTR_W'(1);
      end
    end else begin
      fcnt_d = '0;
      fidx_d = PTR_W'(1);
    end

    if (out_xfer) begin
      for (int i = 0; i < NSLOT; i++) slot_d[i] = NEG_INF;
      ptr_d = '0;
      cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_fp_max_reduce.sv
// Directed bench for fp_max_reduce, run against a LATENCY=1 and a LATENCY=3 instance.

module tb_fp_max_reduce;

  localparam int CNT_W = 16;
  localparam int LAT0  = 1;
  localparam int LAT1  = 3;

  typedef logic [31:0] vec_t [8];

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid  [2];
  logic             in_ready  [2];
  logic [31:0]      in_data   [2];
  logic             in_last   [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [31:0]      out_data  [2];
  logic [CNT_W-1:0] out_count [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cur_lat = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fp_max_reduce #(.LATENCY(LAT0), .CNT_W(CNT_W)) u_dut0 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .in_last   (in_last[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
    .out_count (out_count[0])
  );

  fp_max_reduce #(.LATENCY(LAT1), .CNT_W(CNT_W)) u_dut1 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .in_last   (in_last[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
    .out_count (out_count[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL [L=%0d] %s: got %h, expected %h", cur_lat, tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge; acc_cyc is the cycle count just after the last transfer.
  task automatic send(input int d, input vec_t v, input int n, output int acc_cyc);
    for (int i = 0; i < n; i++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = v[i];
      in_last[d]  = (i == n - 1);
      expect_eq("in_ready during send", 32'(in_ready[d]), 32'd1);
      for (int w = 0; w < 50 && !in_ready[d]; w++) @(negedge clock);
      @(posedge clock);
      @(negedge clock);
    end
    acc_cyc     = cyc;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    in_data[d]  = '0;
  endtask

  task automatic recv(input int d, input int acc_cyc, input logic [31:0] exp_data,
                      input logic [31:0] exp_cnt, input int stall);
    logic [31:0] lat_exp;
    for (int w = 0; w < 200 && !out_valid[d]; w++) @(negedge clock);
    lat_exp = 32'((lat(d) + 1) * (lat(d) + 1));
    expect_eq("out_valid", 32'(out_valid[d]), 32'd1);
    expect_eq("latency", 32'(cyc - acc_cyc + 1), lat_exp);
    expect_eq("out_data", out_data[d], exp_data);
    expect_eq("out_count", 32'(out_count[d]), exp_cnt);
    expect_eq("in_ready in OUTPUT", 32'(in_ready[d]), 32'd0);
    for (int s = 0; s < stall; s++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = 32'h7F00_0000;
      in_last[d]  = 1'b1;
      @(negedge clock);
      expect_eq("stall out_valid", 32'(out_valid[d]), 32'd1);
      expect_eq("stall out_data", out_data[d], exp_data);
      expect_eq("stall out_count", 32'(out_count[d]), exp_cnt);
      expect_eq("stall in_ready", 32'(in_ready[d]), 32'd0);
    end
    in_valid[d]  = 1'b0;
    in_last[d]   = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready[d] = 1'b0;
    expect_eq("out_valid after xfer", 32'(out_valid[d]), 32'd0);
    expect_eq("in_ready after xfer", 32'(in_ready[d]), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   ac;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      in_last[d]   = 1'b0;
      out_ready[d] = 1'b0;
    end
    v = '{default: 32'h0};
    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      cur_lat = lat(d);
      expect_eq("reset in_ready", 32'(in_ready[d]), 32'd0);
      expect_eq("reset out_valid", 32'(out_valid[d]), 32'd0);
      expect_eq("reset out_data", out_data[d], 32'h0);
      expect_eq("reset out_count", 32'(out_count[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      cur_lat = lat(d);
      expect_eq("in_ready after release", 32'(in_ready[d]), 32'd1);
    end

    for (int d = 0; d < 2; d++) begin
      cur_lat = lat(d);

      v = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 0, 0, 0, 0, 0};
      send(d, v, 3, ac);
      recv(d, ac, 32'h4040_0000, 32'd3, 0);

      out_ready[d] = 1'b1;
      repeat (3) begin
        @(negedge clock);
        expect_eq("idle out_valid", 32'(out_valid[d]), 32'd0);
      end
      out_ready[d] = 1'b0;

      v = '{32'hC0A0_0000, 0, 0, 0, 0, 0, 0, 0};
      send(d, v, 1, ac);
      recv(d, ac, 32'hC0A0_0000, 32'd1, 0);

      v = '{32'hC000_0000, 32'hC0E0_0000, 0, 0, 0, 0, 0, 0};
      send(d, v, 2, ac);
      recv(d, ac, 32'hC000_0000, 32'd2, 0);

      v = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hC100_0000,
            32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000, 32'h4040_0000};
      send(d, v, 8, ac);
      recv(d, ac, 32'h40E0_0000, 32'd8, 0);

      v = '{32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 0, 0, 0};
      send(d, v, 2, ac);
      recv(d, ac, 32'h4000_0000, 32'd2, 10);
      v = '{32'h3F00_0000, 0, 0, 0, 0, 0, 0, 0};
      send(d, v, 1, ac);
      recv(d, ac, 32'h3F00_0000, 32'd1, 0);

      v = '{32'h42C8_0000, 0, 0, 0, 0, 0, 0, 0};
      send(d, v, 1, ac);
      repeat (lat(d)) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      expect_eq("mid-fold reset in_ready", 32'(in_ready[d]), 32'd0);
      expect_eq("mid-fold reset out_valid", 32'(out_valid[d]), 32'd0);
      expect_eq("mid-fold reset out_count", 32'(out_count[d]), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      expect_eq("in_ready after mid-fold reset", 32'(in_ready[d]), 32'd1);
      v = '{32'h3F00_0000, 0, 0, 0, 0, 0, 0, 0};
      send(d, v, 1, ac);
      recv(d, ac, 32'h3F00_0000, 32'd1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
